bcd_seq_converter: RTL and testbench
====================================

Name: bcd_seq_converter

Overview:
- Multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
- Sits directly upstream of the 7-segment output stage: takes the processor's output word and produces packed BCD digits for the segment decoder.
- Replaces a wide combinational converter with one shift per clock, driven by a start/busy/done handshake.

Parameters:
- IN_WIDTH, 32, width of binary input; legal 4..32.
- DIGITS, 4, number of BCD digits kept; legal 1..10.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of in; sampled only in IDLE.
- in  input  IN_WIDTH  binary value to convert.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out/overflow/negative update.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- overflow  output  1  result did not fit in DIGITS digits.
- negative  output  1  sign of converted value (see Optional Feature).

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named clk and reset.
- Reset, sampled at a rising edge:
  - State goes to IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0, negative=0.
  - Internal shift, BCD and count registers cleared.
- States:
  - IDLE: busy=0. If start=1 at an edge:
    - Capture in (or its magnitude) into shift register.
    - Clear BCD accumulator and sticky overflow; count=0.
    - Go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - Every accumulator digit >=5 gets +3.
    - Then {accumulator, shift reg} shifts left 1.
    - Bit leaving the top digit ORs into sticky overflow.
    - count increments.
    - On the edge where count reaches IN_WIDTH-1, the final shift result loads bcd_out, overflow and negative, done<=1, state returns to IDLE.
- Latency: start sampled at edge k; busy high from edge k to edge k+IN_WIDTH; done high exactly one cycle after edge k+IN_WIDTH.
- done:
  - Deasserts on the next edge unless a new conversion completes then.
  - A back-to-back start in the done cycle is accepted (state is IDLE).
- start while busy: ignored; no queuing; the in-flight conversion is unaffected.
- in is sampled only on the accepting edge; later changes have no effect.
- Outputs hold their last completed result until the next done; they do not change during SHIFT.
- Overflow:
  - When value >= 10^DIGITS: overflow=1 and bcd_out = value mod 10^DIGITS.
  - The sticky carry-out is exact for this.
- Every output digit is always 0..9.
- Reset mid-conversion: aborts; no done pulse; outputs take their reset values.
- Reset and start in the same cycle: reset wins.

Optional Feature:
- Macro: BCD_SIGNED_INPUT_EN.
- Defined:
  - in is two's complement.
  - On accept, if in[IN_WIDTH-1]=1, the magnitude (-in, IN_WIDTH+1-bit arithmetic) is converted and negative=1 at done; otherwise negative=0.
  - Most-negative value converts to 2^(IN_WIDTH-1) with overflow as applicable.
  - Latency unchanged.
- Undefined: in is unsigned; negative is tied to 0.

Test Plan:
- IN_WIDTH=32, DIGITS=4: reset, then start with in=1234 -> busy high 32 cycles; single done pulse; bcd_out=16'h1234; overflow=0.
- in=9999, then in=0 back-to-back (start in the done cycle) -> first done: bcd_out=16'h9999, overflow=0; second done 32 cycles later: bcd_out=16'h0000.
- in=10000 -> bcd_out=16'h0000, overflow=1. in=123456 -> bcd_out=16'h3456, overflow=1.
- Start in=42, pulse start with in=77 at cycle 10 -> exactly one done at cycle 32 with bcd_out=16'h0042; the second start is ignored.
- Start in=5678, assert reset at cycle 15 -> no done; busy=0 and bcd_out=0 after the reset edge; a fresh start with in=5678 then converts correctly.
- With BCD_SIGNED_INPUT_EN: in=32'hFFFFFFD6 (-42) -> bcd_out=16'h0042, negative=1. in=32'h80000000 -> overflow=1, bcd_out=16'h3648, negative=1.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) with start/busy/done handshake.
// Optional two's-complement input handling is enabled by defining BCD_SIGNED_INPUT_EN.
module bcd_seq_converter #(
    parameter int IN_WIDTH = 32,
    parameter int DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  negative
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              state_r, state_nx_s;
    logic [IN_WIDTH-1:0] shift_r, shift_nx_s;
    logic [BCD_W-1:0]    acc_r, acc_nx_s;
    logic                sticky_r, sticky_nx_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
    logic                neg_pend_r, neg_pend_nx_s;
    logic                busy_r, busy_nx_s;
    logic                done_r, done_nx_s;
    logic [BCD_W-1:0]    bcd_out_r, bcd_out_nx_s;
    logic                overflow_r, overflow_nx_s;
    logic                negative_r, negative_nx_s;

    logic [IN_WIDTH-1:0] mag_s;
    logic                neg_in_s;
    logic [BCD_W-1:0]    acc_adj_s;
    logic [BCD_W-1:0]    acc_shift_s;
    logic [IN_WIDTH-1:0] shift_shift_s;
    logic                carry_s;

    // Digits >= 5 get +3 so the following left shift carries correctly into the next decade.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = a[4*i +: 4];
            end
        end
        return r;
    endfunction

`ifdef BCD_SIGNED_INPUT_EN
    // Negation modulo 2^IN_WIDTH: the most-negative value maps to 2^(IN_WIDTH-1), which fits unsigned.
    assign neg_in_s = in[IN_WIDTH-1];
    assign mag_s    = neg_in_s ? ((~in) + IN_WIDTH'(1)) : in;
`else
    assign neg_in_s = 1'b0;
    assign mag_s    = in;
`endif

    assign acc_adj_s     = add3_all(acc_r);
    assign carry_s       = acc_adj_s[BCD_W-1];
    assign acc_shift_s   = {acc_adj_s[BCD_W-2:0], shift_r[IN_WIDTH-1]};
    assign shift_shift_s = {shift_r[IN_WIDTH-2:0], 1'b0};

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_nx_s    = state_r;
        shift_nx_s    = shift_r;
        acc_nx_s      = acc_r;
        sticky_nx_s   = sticky_r;
        cnt_nx_s      = cnt_r;
        neg_pend_nx_s = neg_pend_r;
        busy_nx_s     = busy_r;
        done_nx_s     = 1'b0;
        bcd_out_nx_s  = bcd_out_r;
        overflow_nx_s = overflow_r;
        negative_nx_s = negative_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s    = ST_SHIFT;
                    shift_nx_s    = mag_s;
                    acc_nx_s      = '0;
                    sticky_nx_s   = 1'b0;
                    cnt_nx_s      = '0;
                    neg_pend_nx_s = neg_in_s;
                    busy_nx_s     = 1'b1;
                end else begin
                    busy_nx_s     = 1'b0;
                end
            end
            ST_SHIFT: begin
                acc_nx_s    = acc_shift_s;
                shift_nx_s  = shift_shift_s;
                sticky_nx_s = sticky_r | carry_s;
                cnt_nx_s    = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_W'(IN_WIDTH - 1)) begin
                    state_nx_s    = ST_IDLE;
                    busy_nx_s     = 1'b0;
                    done_nx_s     = 1'b1;
                    bcd_out_nx_s  = acc_shift_s;
                    overflow_nx_s = sticky_r | carry_s;
                    negative_nx_s = neg_pend_r;
                end else begin
                    busy_nx_s     = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            acc_r      <= '0;
            sticky_r   <= 1'b0;
            cnt_r      <= '0;
            neg_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bcd_out_r  <= '0;
            overflow_r <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            shift_r    <= shift_nx_s;
            acc_r      <= acc_nx_s;
            sticky_r   <= sticky_nx_s;
            cnt_r      <= cnt_nx_s;
            neg_pend_r <= neg_pend_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
            bcd_out_r  <= bcd_out_nx_s;
            overflow_r <= overflow_nx_s;
            negative_r <= negative_nx_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcd_out  = bcd_out_r;
    assign overflow = overflow_r;
    assign negative = negative_r;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter (IN_WIDTH=32, DIGITS=4): directed cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bcd_seq_converter;

    localparam int IN_WIDTH = 32;
    localparam int DIGITS   = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic [IN_WIDTH-1:0] in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                overflow;
    logic                negative;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] prev_b = 16'h0000;
    logic        prev_o = 1'b0;

    bcd_seq_converter #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .start(start), .in(in),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .overflow(overflow), .negative(negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the (magnitude of the) value, modulo 10^DIGITS.
    function automatic void model(input logic [31:0] v, output logic [15:0] b,
                                  output logic o, output logic n);
        longint unsigned mag;
`ifdef BCD_SIGNED_INPUT_EN
        n   = v[31];
        mag = n ? (64'd4294967296 - longint'(v)) : longint'(v);
`else
        n   = 1'b0;
        mag = longint'(v);
`endif
        o   = (mag >= 64'd10000);
        mag = mag % 64'd10000;
        b   = 16'h0000;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'(mag % 64'd10);
            mag = mag / 64'd10;
        end
    endfunction

    // Called at a negedge: present start for one edge, then scramble in.
    task automatic do_start(input logic [31:0] v);
        start = 1'b1;
        in    = v;
        @(negedge clk);
        start = 1'b0;
        in    = $urandom;
    endtask

    task automatic finish_check(input logic [31:0] v, input int exp_n, input string tag);
        int          n;
        bit          hold_ok;
        logic [15:0] eb;
        logic        eo;
        logic        en;
        n       = 0;
        hold_ok = 1'b1;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1 || bcd_out !== prev_b || overflow !== prev_o) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        model(v, eb, eo, en);
        check({tag, "_latency"}, 64'(n), 64'(exp_n));
        check({tag, "_busy_hold"}, 64'(hold_ok), 64'd1);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_bcd"}, 64'(bcd_out), 64'(eb));
        check({tag, "_ovf"}, 64'(overflow), 64'(eo));
        check({tag, "_neg"}, 64'(negative), 64'(en));
        prev_b = eb;
        prev_o = eo;
    endtask

    initial begin
        bit          quiet_ok;
        logic [31:0] v;

        reset = 1'b1;
        start = 1'b0;
        in    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd_out), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_neg", 64'(negative), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        do_start(32'd1234);
        check("busy_after_start", 64'(busy), 64'd1);
        finish_check(32'd1234, 32, "c1234");
        @(negedge clk);
        check("done_pulse_1234", 64'(done), 64'd0);

        // 9999 then 0 with start raised in the done cycle
        do_start(32'd9999);
        finish_check(32'd9999, 32, "c9999");
        do_start(32'd0);
        check("b2b_done_drop", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        finish_check(32'd0, 32, "c0");
        @(negedge clk);

        do_start(32'd10000);
        finish_check(32'd10000, 32, "c10000");
        @(negedge clk);
        do_start(32'd123456);
        finish_check(32'd123456, 32, "c123456");
        @(negedge clk);

        // start while busy is ignored
        do_start(32'd42);
        repeat (9) @(negedge clk);
        do_start(32'd77);
        finish_check(32'd42, 22, "c42");
        quiet_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
        end
        check("ignored_start_quiet", 64'(quiet_ok), 64'd1);

        // reset mid-conversion aborts
        do_start(32'd5678);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_bcd", 64'(bcd_out), 64'd0);
        check("midrst_ovf", 64'(overflow), 64'd0);
        prev_b = 16'h0000;
        prev_o = 1'b0;
        quiet_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
        end
        check("midrst_quiet", 64'(quiet_ok), 64'd1);
        do_start(32'd5678);
        finish_check(32'd5678, 32, "c5678");
        @(negedge clk);

        // reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        in    = 32'd321;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);
        check("rst_start_bcd", 64'(bcd_out), 64'd0);
        prev_b = 16'h0000;
        prev_o = 1'b0;

`ifdef BCD_SIGNED_INPUT_EN
        do_start(32'hFFFFFFD6);
        finish_check(32'hFFFFFFD6, 32, "s_m42");
        @(negedge clk);
        do_start(32'h80000000);
        finish_check(32'h80000000, 32, "s_min");
        @(negedge clk);
`endif

        for (int i = 0; i < 24; i++) begin
            v = (i % 2 == 1) ? $urandom : 32'($urandom_range(0, 20000));
            do_start(v);
            finish_check(v, 32, "rand");
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check("rand_done_drop", 64'(done), 64'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
